// File: rtl/pc_select_reg.sv
// Fetch-stage next-PC selector with the PC register and a one-deep redirect buffer for stalls.
// Optional PC_ALIGN_CHECK_EN: misaligned targets (bits [1:0] != 0) are rejected like an illegal select.
module pc_select_reg #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_IN    = 4,
  parameter int               SEL_W     = 2,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h00400030)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    redir_req,
  input  logic                    stall,
  output logic [WIDTH-1:0]        pc_out,
  output logic                    pc_valid,
  output logic                    redir_pending,
  output logic                    sel_err
);

  localparam int               NSLOT = 2**SEL_W;
  localparam logic [SEL_W:0]   NUM_L = (SEL_W+1)'(NUM_IN);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] tgt;
  } pend_t;

  // Pad the source table to every encodable select so sel can index it without range issues.
  logic [NSLOT-1:0][WIDTH-1:0] src;
  for (genvar k = 0; k < NSLOT; k++) begin : g_src
    if (k < NUM_IN) begin : g_live
      assign src[k] = in_flat[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign src[k] = '0;
    end
  end

  logic [WIDTH-1:0] pc_q, pc_nxt, tgt;
  pend_t            pend_q, pend_nxt;
  logic             sel_ok, tgt_ok, seq_ok, err_nxt;

  always_comb begin
    pc_nxt   = pc_q;
    pend_nxt = pend_q;
    err_nxt  = 1'b0;
    tgt      = src[sel];
    sel_ok   = {1'b0, sel} < NUM_L;
`ifdef PC_ALIGN_CHECK_EN
    tgt_ok   = (tgt[1:0] == 2'b00);
    seq_ok   = (src[0][1:0] == 2'b00);
`else
    tgt_ok   = 1'b1;
    seq_ok   = 1'b1;
`endif
    if (redir_req && !(sel_ok && tgt_ok)) begin
      err_nxt = 1'b1;
    end else if (redir_req) begin
      // A live redirect always supersedes whatever was buffered.
      if (stall) begin
        pend_nxt.vld = 1'b1;
        pend_nxt.tgt = tgt;
      end else begin
        pc_nxt       = tgt;
        pend_nxt.vld = 1'b0;
      end
    end else if (!stall) begin
      if (pend_q.vld) begin
        pc_nxt       = pend_q.tgt;
        pend_nxt.vld = 1'b0;
      end else if (seq_ok) begin
        pc_nxt = src[0];
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_VEC;
      pend_q   <= '0;
      pc_valid <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      pc_q     <= pc_nxt;
      pend_q   <= pend_nxt;
      pc_valid <= 1'b1;
      sel_err  <= err_nxt;
    end
  end

  assign pc_out        = pc_q;
  assign redir_pending = pend_q.vld;

endmodule

// File: tb/tb_pc_select_reg.sv
// Bench for pc_select_reg: directed table, hand sequences and random stimulus against a reference model.
module tb_pc_select_reg;
  logic        clk = 1'b0;
  logic        rst_n, stall, req;
  logic [1:0]  sel;
  logic [31:0] in_v [4];
  logic [127:0] in_flat;
  logic [31:0] pc4, pc3;
  logic        v4, v3, p4, p3, e4, e3;

  assign in_flat = {in_v[3], in_v[2], in_v[1], in_v[0]};

  always #5 clk = ~clk;

  pc_select_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_flat(in_flat), .sel(sel), .redir_req(req), .stall(stall),
    .pc_out(pc4), .pc_valid(v4), .redir_pending(p4), .sel_err(e4));

  pc_select_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_flat(in_flat[95:0]), .sel(sel), .redir_req(req), .stall(stall),
    .pc_out(pc3), .pc_valid(v3), .redir_pending(p3), .sel_err(e3));

  int total = 0, passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else passed++;
  endtask

  // Reference model: index 0 mirrors the 4-source instance, index 1 the 3-source one.
  logic [31:0] m_pc [2];
  bit          m_valid [2], m_err [2], m_has [2];
  logic [31:0] m_tgt [2];

  function automatic bit misaligned(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int num = (m == 0) ? 4 : 3;
      if (!rst_n) begin
        m_pc[m] = 32'h00400030; m_valid[m] = 0; m_err[m] = 0; m_has[m] = 0;
      end else begin
        m_valid[m] = 1;
        m_err[m]   = 0;
        if (req && (int'(sel) >= num || misaligned(in_v[sel]))) m_err[m] = 1;
        else if (req && stall) begin m_has[m] = 1; m_tgt[m] = in_v[sel]; end
        else if (req) begin m_pc[m] = in_v[sel]; m_has[m] = 0; end
        else if (!stall) begin
          if (m_has[m]) begin m_pc[m] = m_tgt[m]; m_has[m] = 0; end
          else if (misaligned(in_v[0])) m_err[m] = 1;
          else m_pc[m] = in_v[0];
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("model_pc4", pc4, m_pc[0]);   chk("model_valid4", 32'(v4), 32'(m_valid[0]));
    chk("model_pend4", 32'(p4), 32'(m_has[0])); chk("model_err4", 32'(e4), 32'(m_err[0]));
    chk("model_pc3", pc3, m_pc[1]);   chk("model_valid3", 32'(v3), 32'(m_valid[1]));
    chk("model_pend3", 32'(p3), 32'(m_has[1])); chk("model_err3", 32'(e3), 32'(m_err[1]));
  endtask

  typedef struct {
    bit          rst_n, stall, req;
    logic [1:0]  sel;
    logic [31:0] i0, i1, i2, i3;
    logic [31:0] pc;
    bit          valid, pend, err;
  } vec_t;

  vec_t tbl [16];

  initial begin
    rst_n = 0; stall = 0; req = 0; sel = 0;
    for (int i = 0; i < 4; i++) in_v[i] = 32'h0;

    //          rst st rq sel  in0           in1           in2           in3           pc            v  p  e
    tbl[0]  = '{0, 0, 0, 2'd0, 32'h00400034, 32'h0,        32'h0,        32'h0,        32'h00400030, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 2'd0, 32'h00400034, 32'h0,        32'h0,        32'h0,        32'h00400030, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 2'd0, 32'h00400034, 32'h0,        32'h0,        32'h0,        32'h00400034, 1, 0, 0};
    tbl[3]  = '{1, 0, 1, 2'd2, 32'h00400038, 32'h0,        32'h00400100, 32'h0,        32'h00400100, 1, 0, 0};
    tbl[4]  = '{1, 1, 1, 2'd1, 32'h00400104, 32'h00400200, 32'h0,        32'h0,        32'h00400100, 1, 1, 0};
    tbl[5]  = '{1, 1, 1, 2'd3, 32'h00400104, 32'h0,        32'h0,        32'h00400300, 32'h00400100, 1, 1, 0};
    tbl[6]  = '{1, 1, 0, 2'd3, 32'h00400104, 32'h0,        32'h0,        32'h00400aa0, 32'h00400100, 1, 1, 0};
    tbl[7]  = '{1, 0, 0, 2'd0, 32'h00400104, 32'h0,        32'h0,        32'h0,        32'h00400300, 1, 0, 0};
    tbl[8]  = '{1, 1, 1, 2'd1, 32'h00400304, 32'h00400400, 32'h0,        32'h0,        32'h00400300, 1, 1, 0};
    tbl[9]  = '{1, 0, 1, 2'd2, 32'h00400304, 32'h0,        32'h00400500, 32'h0,        32'h00400500, 1, 0, 0};
    tbl[10] = '{1, 0, 0, 2'd0, 32'h00400504, 32'h0,        32'h0,        32'h0,        32'h00400504, 1, 0, 0};
`ifdef PC_ALIGN_CHECK_EN
    tbl[11] = '{1, 0, 1, 2'd2, 32'h00400508, 32'h0,        32'h00400102, 32'h0,        32'h00400504, 1, 0, 1};
`else
    tbl[11] = '{1, 0, 1, 2'd2, 32'h00400508, 32'h0,        32'h00400102, 32'h0,        32'h00400102, 1, 0, 0};
`endif
    tbl[12] = '{1, 0, 0, 2'd0, 32'h00400600, 32'h0,        32'h0,        32'h0,        32'h00400600, 1, 0, 0};
    tbl[13] = '{1, 1, 1, 2'd2, 32'h00400604, 32'h0,        32'h00400700, 32'h0,        32'h00400600, 1, 1, 0};
    tbl[14] = '{0, 1, 0, 2'd0, 32'h00400604, 32'h0,        32'h0,        32'h0,        32'h00400030, 0, 0, 0};
    tbl[15] = '{1, 0, 0, 2'd0, 32'h00400034, 32'h0,        32'h0,        32'h0,        32'h00400034, 1, 0, 0};

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      rst_n = tbl[i].rst_n; stall = tbl[i].stall; req = tbl[i].req; sel = tbl[i].sel;
      in_v[0] = tbl[i].i0; in_v[1] = tbl[i].i1; in_v[2] = tbl[i].i2; in_v[3] = tbl[i].i3;
      cycle();
      chk($sformatf("tbl%0d_pc", i),    pc4, tbl[i].pc);
      chk($sformatf("tbl%0d_valid", i), 32'(v4), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_pend", i),  32'(p4), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d_err", i),   32'(e4), 32'(tbl[i].err));
    end

    // Out-of-range select on the 3-source instance, during and after a stall with a buffered target.
    in_v[0] = 32'h00400034;
    stall = 1; req = 1; sel = 2'd1; in_v[1] = 32'h00400800; cycle();
    chk("h1_pc3", pc3, 32'h00400034); chk("h1_pend3", 32'(p3), 1); chk("h1_err3", 32'(e3), 0);
    stall = 1; req = 1; sel = 2'd3; in_v[3] = 32'h00400900; cycle();
    chk("h2_pc3", pc3, 32'h00400034); chk("h2_pend3", 32'(p3), 1); chk("h2_err3", 32'(e3), 1);
    stall = 0; req = 1; sel = 2'd3; cycle();
    chk("h3_pc3", pc3, 32'h00400034); chk("h3_pend3", 32'(p3), 1); chk("h3_err3", 32'(e3), 1);
    chk("h3_pc4", pc4, 32'h00400900);
    stall = 0; req = 0; sel = 2'd0; cycle();
    chk("h4_pc3", pc3, 32'h00400800); chk("h4_pend3", 32'(p3), 0); chk("h4_err3", 32'(e3), 0);

    // Random traffic, occasionally misaligned targets and resets.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      stall = ($urandom_range(0, 9) < 3);
      req   = ($urandom_range(0, 9) < 4);
      sel   = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin
        in_v[k] = {16'h0040, 16'($urandom)} & 32'hffff_fffc;
        if ($urandom_range(0, 7) == 0) in_v[k][1:0] = 2'($urandom_range(1, 3));
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
